// File: rtl/mac_tile_engine.sv
// ROWS x COLS outer-product MAC array: K-beat accumulate over a valid/ready
// operand port, saturating accumulators, row-serial drain over a valid/ready result port.
module mac_tile_engine #(
    parameter int unsigned ROWS        = 8,
    parameter int unsigned COLS        = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [15:0]                k_len_i,
    input  logic                       mode_i,
    input  logic                       abort_i,
    input  logic                       a_valid_i,
    output logic                       a_ready_o,
    input  logic [ROWS*DATA_W-1:0]     a_row_i,
    input  logic [COLS*DATA_W-1:0]     b_col_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [COLS*ACC_W-1:0]      out_row_o,
    output logic [$clog2(ROWS)-1:0]    out_row_idx_o,
    output logic                       out_last_o,
    output logic                       busy_o,
    output logic                       sat_flag_o
);

    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned FL_W   = $clog2(PIPE_STAGES + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [15:0]              issued_q, issued_d;
    logic [15:0]              k_q, k_d;
    logic                     mode_q, mode_d;
    logic [FL_W-1:0]          flush_q, flush_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic                     sat_q;
    logic [PIPE_STAGES-1:0]   vld_q;
    logic                     accept_c;
    logic                     clear_c;
    logic                     sat_hit_c;
    logic signed [SUM_W-1:0]  sum_c;

    logic signed [DATA_W-1:0] a_dec_c [ROWS];
    logic signed [DATA_W-1:0] b_dec_c [COLS];
    logic signed [PROD_W-1:0] prod_c  [ROWS][COLS];
    logic signed [PROD_W-1:0] prod_q  [PIPE_STAGES][ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_q   [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_d   [ROWS][COLS];

    // int8 keeps only the low byte of each lane, sign-extended
    function automatic logic signed [DATA_W-1:0] decode(input logic [DATA_W-1:0] lane,
                                                        input logic wide);
        logic signed [7:0] lo;
        lo = lane[7:0];
        return wide ? $signed(lane) : DATA_W'(lo);
    endfunction

    // Next-state and handshake logic
    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        k_d       = k_q;
        mode_d    = mode_q;
        flush_d   = flush_q;
        row_d     = row_q;
        clear_c   = 1'b0;
        a_ready_o = (state_q == S_ACCUM) && (issued_q < k_q);
        accept_c  = a_valid_i && a_ready_o && !abort_i;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && (k_len_i != 16'd0)) begin
                    clear_c  = 1'b1;
                    k_d      = k_len_i;
                    mode_d   = mode_i;
                    issued_d = 16'd0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept_c) begin
                    issued_d = issued_q + 16'd1;
                    if ((issued_q + 16'd1) == k_q) begin
                        flush_d = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FL_W'(PIPE_STAGES - 1)) begin
                    row_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready_i) begin
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            row_d   = '0;
            clear_c = 1'b0;
        end
    end

    // Operand decode and full-precision outer product
    always_comb begin
        for (int i = 0; i < ROWS; i++) a_dec_c[i] = decode(a_row_i[i*DATA_W +: DATA_W], mode_q);
        for (int j = 0; j < COLS; j++) b_dec_c[j] = decode(b_col_i[j*DATA_W +: DATA_W], mode_q);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                prod_c[i][j] = PROD_W'(a_dec_c[i]) * PROD_W'(b_dec_c[j]);
            end
        end
    end

    // Saturating accumulate; a mismatch between the two top sum bits is an overflow
    always_comb begin
        sat_hit_c = 1'b0;
        sum_c     = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                sum_c = SUM_W'(acc_q[i][j]) + SUM_W'(prod_q[PIPE_STAGES-1][i][j]);
                if (sum_c[SUM_W-1] != sum_c[ACC_W-1]) begin
                    acc_d[i][j] = sum_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
                    sat_hit_c   = 1'b1;
                end else begin
                    acc_d[i][j] = sum_c[ACC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            k_q      <= '0;
            mode_q   <= 1'b0;
            flush_q  <= '0;
            row_q    <= '0;
            sat_q    <= 1'b0;
            vld_q    <= '0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) acc_q[i][j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            flush_q  <= flush_d;
            row_q    <= row_d;
            vld_q[0] <= accept_c;
            for (int s = 1; s < PIPE_STAGES; s++) vld_q[s] <= vld_q[s-1] && !abort_i;
            if (clear_c) begin
                sat_q <= 1'b0;
                for (int i = 0; i < ROWS; i++) begin
                    for (int j = 0; j < COLS; j++) acc_q[i][j] <= '0;
                end
            end else if (vld_q[PIPE_STAGES-1] && !abort_i) begin
                acc_q <= acc_d;
                sat_q <= sat_q | sat_hit_c;
            end
        end
    end

    // Product delay line; qualified by vld_q so data needs no reset
    always_ff @(posedge clk) begin
        if (accept_c) prod_q[0] <= prod_c;
        for (int s = 1; s < PIPE_STAGES; s++) prod_q[s] <= prod_q[s-1];
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        out_valid_o   = (state_q == S_DRAIN);
        out_last_o    = (state_q == S_DRAIN) && (row_q == ROW_W'(ROWS - 1));
        out_row_idx_o = row_q;
        sat_flag_o    = sat_q;
        out_row_o     = '0;
        for (int c = 0; c < COLS; c++) out_row_o[c*ACC_W +: ACC_W] = acc_q[row_q][c];
    end

endmodule

// File: tb/tb_mac_tile_engine.sv
// Self-checking bench for mac_tile_engine: directed and random sequences
// compared against an arithmetic model of the accumulator array.
module tb_mac_tile_engine;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int PIPE   = 3;
    localparam longint ACC_MAXL = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MINL = -(longint'(1) <<< (ACC_W - 1));

    typedef logic [ROWS*DATA_W-1:0] a_t;
    typedef logic [COLS*DATA_W-1:0] b_t;

    logic                     clk;
    logic                     rst_n;
    logic                     start_i;
    logic [15:0]              k_len_i;
    logic                     mode_i;
    logic                     abort_i;
    logic                     a_valid_i;
    logic                     a_ready_o;
    a_t                       a_row_i;
    b_t                       b_col_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [COLS*ACC_W-1:0]    out_row_o;
    logic [$clog2(ROWS)-1:0]  out_row_idx_o;
    logic                     out_last_o;
    logic                     busy_o;
    logic                     sat_flag_o;

    int checks = 0;
    int errors = 0;
    longint            exp_acc [ROWS][COLS];
    bit                exp_sat;
    logic signed [63:0] got    [ROWS][COLS];
    a_t beat_a[$];
    b_t beat_b[$];

    mac_tile_engine #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .PIPE_STAGES(PIPE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i), .mode_i(mode_i),
        .abort_i(abort_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .a_row_i(a_row_i), .b_col_i(b_col_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_row_o(out_row_o), .out_row_idx_o(out_row_idx_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .sat_flag_o(sat_flag_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [63:0] lane(input int c);
        logic signed [ACC_W-1:0] v;
        v = out_row_o[c*ACC_W +: ACC_W];
        return 64'(v);
    endfunction

    function automatic longint dec(input logic [DATA_W-1:0] v, input bit md);
        logic signed [7:0]  lo;
        logic signed [15:0] w;
        lo = v[7:0];
        w  = v;
        return md ? longint'(w) : longint'(lo);
    endfunction

    function automatic a_t rnd_lanes();
        a_t v;
        for (int i = 0; i < ROWS; i++) begin
            case ($urandom_range(3))
                0:       v[i*DATA_W +: DATA_W] = 16'h7FFF;
                1:       v[i*DATA_W +: DATA_W] = 16'h8000;
                default: v[i*DATA_W +: DATA_W] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Model: every beat adds the outer product, clamped to the signed accumulator range
    task automatic model_beat(input a_t a, input b_t b, input bit md);
        longint s;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                s = exp_acc[i][j] + dec(a[i*DATA_W +: DATA_W], md) * dec(b[j*DATA_W +: DATA_W], md);
                if (s > ACC_MAXL) begin
                    s = ACC_MAXL;
                    exp_sat = 1'b1;
                end else if (s < ACC_MINL) begin
                    s = ACC_MINL;
                    exp_sat = 1'b1;
                end
                exp_acc[i][j] = s;
            end
        end
    endtask

    task automatic feed(input int k, input bit md, input int gap, input int bub_pct);
        int acc_cnt;
        int cyc;
        int forced;
        int n;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) exp_acc[i][j] = 0;
        exp_sat   = 1'b0;
        start_i   = 1'b1;
        k_len_i   = 16'(k);
        mode_i    = md;
        a_valid_i = 1'b0;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        chk("sat_cleared_on_start", sat_flag_o, 0);
        acc_cnt = 0;
        cyc     = 0;
        forced  = 0;
        while (acc_cnt < k && cyc < 2000) begin
            start_i = 1'($urandom_range(1));
            k_len_i = 16'($urandom);
            mode_i  = 1'($urandom_range(1));
            if (forced > 0 || int'($urandom_range(99)) < bub_pct) begin
                a_valid_i = 1'b0;
                a_row_i   = rnd_lanes();
                b_col_i   = rnd_lanes();
                if (forced > 0) forced--;
            end else begin
                a_valid_i = 1'b1;
                a_row_i   = beat_a[acc_cnt];
                b_col_i   = beat_b[acc_cnt];
            end
            chk("a_ready_in_accum", a_ready_o, 1);
            if (a_valid_i) begin
                model_beat(beat_a[acc_cnt], beat_b[acc_cnt], md);
                acc_cnt++;
                forced = gap;
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
        chk("beats_accepted", acc_cnt, k);
        a_valid_i = 1'b1;
        a_row_i   = rnd_lanes();
        b_col_i   = rnd_lanes();
        chk("a_ready_after_last", a_ready_o, 0);
        n = 0;
        while (out_valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
            chk("extra_beat_not_taken", a_ready_o, 0);
        end
        chk("first_out_latency", n, PIPE);
        a_valid_i = 1'b0;
    endtask

    task automatic drain(input int stall_row, input int rdy_pct);
        int rows;
        int cyc;
        bit stalled;
        logic signed [63:0] snap [COLS];
        logic [$clog2(ROWS)-1:0] sidx;
        rows    = 0;
        cyc     = 0;
        stalled = 1'b0;
        while (rows < ROWS && cyc < 2000) begin
            chk("drain_valid", out_valid_o, 1);
            sidx = out_row_idx_o;
            for (int c = 0; c < COLS; c++) snap[c] = lane(c);
            if (!stalled && int'(out_row_idx_o) == stall_row) begin
                stalled     = 1'b1;
                out_ready_i = 1'b0;
                repeat (5) begin
                    tick();
                    cyc++;
                    chk("stall_valid", out_valid_o, 1);
                    chk("stall_idx", out_row_idx_o, sidx);
                    for (int c = 0; c < COLS; c++) chk($sformatf("stall_lane%0d", c), lane(c), snap[c]);
                end
            end else begin
                out_ready_i = (int'($urandom_range(99)) < rdy_pct);
                if (out_ready_i) begin
                    chk("row_idx_order", out_row_idx_o, rows);
                    chk("row_last", out_last_o, (rows == ROWS - 1));
                    for (int c = 0; c < COLS; c++) begin
                        got[rows][c] = lane(c);
                        chk($sformatf("acc_r%0d_c%0d", rows, c), got[rows][c], exp_acc[rows][c]);
                    end
                    rows++;
                    tick();
                end else begin
                    tick();
                    chk("hold_idx", out_row_idx_o, sidx);
                    chk("hold_lane0", lane(0), snap[0]);
                    chk("hold_lane_last", lane(COLS - 1), snap[COLS - 1]);
                end
                cyc++;
            end
        end
        out_ready_i = 1'b0;
        chk("drain_rows", rows, ROWS);
        chk("valid_low_after_drain", out_valid_o, 0);
        chk("busy_low_after_drain", busy_o, 0);
        chk("sat_flag", sat_flag_o, exp_sat);
    endtask

    task automatic fill_beats(input int n, input int av, input int bv);
        a_t a;
        b_t b;
        for (int i = 0; i < ROWS; i++) a[i*DATA_W +: DATA_W] = 16'(av);
        for (int j = 0; j < COLS; j++) b[j*DATA_W +: DATA_W] = 16'(bv);
        repeat (n) begin
            beat_a.push_back(a);
            beat_b.push_back(b);
        end
    endtask

    initial begin
        a_t ta;
        b_t tb;
        int k;
        rst_n = 1'b0; start_i = 1'b0; k_len_i = '0; mode_i = 1'b0; abort_i = 1'b0;
        a_valid_i = 1'b0; a_row_i = '0; b_col_i = '0; out_ready_i = 1'b0;
        #3;
        chk("rst_a_ready", a_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sat", sat_flag_o, 0);
        chk("rst_last", out_last_o, 0);
        chk("rst_idx", out_row_idx_o, 0);
        chk("rst_row_lane0", lane(0), 0);
        chk("rst_row_lane7", lane(7), 0);
        #9 rst_n = 1'b1;
        tick();

        start_i = 1'b1; k_len_i = 16'd0;
        tick();
        start_i = 1'b0;
        chk("klen0_ignored", busy_o, 0);

        // int8 single beat
        beat_a.delete(); beat_b.delete();
        for (int i = 0; i < ROWS; i++) ta[i*DATA_W +: DATA_W] = 16'(i + 2);
        for (int j = 0; j < COLS; j++) tb[j*DATA_W +: DATA_W] = 16'(j + 1);
        beat_a.push_back(ta); beat_b.push_back(tb);
        feed(1, 1'b0, 0, 0);
        drain(-1, 100);
        chk("t1_r0c0", got[0][0], 2);
        chk("t1_r0c7", got[0][7], 16);
        chk("t1_r7c7", got[7][7], 72);

        // int16 scaled lanes
        beat_a.delete(); beat_b.delete();
        for (int i = 0; i < ROWS; i++) ta[i*DATA_W +: DATA_W] = 16'(100 * (i + 1));
        for (int j = 0; j < COLS; j++) tb[j*DATA_W +: DATA_W] = 16'(10 * (j + 1));
        beat_a.push_back(ta); beat_b.push_back(tb);
        feed(1, 1'b1, 0, 20);
        drain(-1, 70);
        chk("t2_r7c7", got[7][7], 64000);
        chk("t2_r0c0", got[0][0], 1000);

        // int8 ignores upper lane bits and sign-extends the low byte
        beat_a.delete(); beat_b.delete();
        ta = rnd_lanes(); tb = rnd_lanes();
        ta[15:0] = 16'h0320; ta[31:16] = 16'h00FD;
        tb[15:0] = 16'h0050; tb[31:16] = 16'h0007;
        beat_a.push_back(ta); beat_b.push_back(tb);
        feed(1, 1'b0, 0, 0);
        drain(-1, 100);
        chk("t2_int8_r0c0", got[0][0], 2560);
        chk("t2_int8_r1c1", got[1][1], -21);

        // Two beats separated by three bubbles
        beat_a.delete(); beat_b.delete();
        fill_beats(1, 2, 3);
        fill_beats(1, 4, 5);
        feed(2, 1'b0, 3, 0);
        drain(-1, 100);
        chk("t3_r0c0", got[0][0], 26);

        // Positive then negative saturation
        beat_a.delete(); beat_b.delete();
        fill_beats(3, 16'h7FFF, 16'h7FFF);
        feed(3, 1'b1, 0, 0);
        drain(-1, 100);
        chk("t4_pos_clamp", got[0][0], 64'sd2147483647);
        chk("t4_pos_sat", sat_flag_o, 1);
        beat_a.delete(); beat_b.delete();
        fill_beats(3, 16'h8000, 16'h7FFF);
        feed(3, 1'b1, 0, 0);
        drain(-1, 100);
        chk("t4_neg_clamp", got[3][5], -64'sd2147483648);
        chk("t4_neg_sat", sat_flag_o, 1);

        // Backpressure held on row 3
        beat_a.delete(); beat_b.delete();
        for (int n = 0; n < 4; n++) begin
            beat_a.push_back(rnd_lanes());
            beat_b.push_back(rnd_lanes());
        end
        feed(4, 1'b1, 0, 30);
        drain(3, 60);

        // Abort together with start after one of four beats
        start_i = 1'b1; k_len_i = 16'd4; mode_i = 1'b1;
        tick();
        start_i = 1'b0;
        a_valid_i = 1'b1; a_row_i = rnd_lanes(); b_col_i = rnd_lanes();
        chk("abort_pre_ready", a_ready_o, 1);
        tick();
        a_valid_i = 1'b0; abort_i = 1'b1; start_i = 1'b1; k_len_i = 16'd4;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_a_ready", a_ready_o, 0);
        chk("abort_out_valid", out_valid_o, 0);
        repeat (PIPE + 4) begin
            tick();
            chk("abort_no_valid", out_valid_o, 0);
            chk("abort_stays_idle", busy_o, 0);
        end

        // Random sequences
        repeat (6) begin
            k = int'($urandom_range(1, 6));
            beat_a.delete(); beat_b.delete();
            for (int n = 0; n < k; n++) begin
                beat_a.push_back(rnd_lanes());
                beat_b.push_back(rnd_lanes());
            end
            feed(k, 1'($urandom_range(1)), int'($urandom_range(0, 2)), 25);
            drain(-1, 50);
        end

        // Asynchronous reset in the middle of the drain
        beat_a.delete(); beat_b.delete();
        fill_beats(3, 16'h7FFF, 16'h7FFF);
        feed(3, 1'b1, 0, 0);
        out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        chk("pre_rst_idx", out_row_idx_o, 2);
        chk("pre_rst_sat", sat_flag_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid_o, 0);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_sat", sat_flag_o, 0);
        chk("async_rst_idx", out_row_idx_o, 0);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
